// File: rtl/seg_scan_driver.sv
// Six-digit 7-segment scan driver: one digit per slot, blanking at the start of each slot, frame-atomic capture.
// Optional digit blinking is compiled in with `define SEG_BLINK_EN.
//
// state   | meaning
// S_BLANK | slot lead-in, all enables/segments inactive (anti-ghosting)
// S_DRIVE | enable of digit idx active, its segments and dp driven
module seg_scan_driver #(
  parameter int DIV_CNT     = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit ENB_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b0
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [41:0] i_six_digit_seg,
  input  logic [5:0]  i_six_dp,
`ifdef SEG_BLINK_EN
  input  logic [5:0]  i_blink_mask,
`endif
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic [5:0]  o_seg_enb,
  output logic        o_frame_start
);

  localparam int CW = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CNT - 1);
  localparam logic [5:0] ENB_OFF = {6{ENB_ACT_LOW}};
  localparam logic [6:0] SEG_OFF = {7{SEG_ACT_LOW}};
  localparam logic       DP_OFF  = SEG_ACT_LOW;

  if (DIV_CNT < 2) begin : g_bad_div
    $error("seg_scan_driver: DIV_CNT must be >= 2");
  end
  if (BLANK_CYC >= DIV_CNT || BLANK_CYC < 0) begin : g_bad_blank
    $error("seg_scan_driver: BLANK_CYC must be in 0..DIV_CNT-1");
  end

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    idx, idx_next;
  logic          tick;
  logic          frame_end;
  logic [41:0]   shadow_seg;
  logic [5:0]    shadow_dp;
  logic [5:0]    enb_onehot;
  logic [6:0]    seg_sel;
  logic          dp_sel;
  logic          blink_dark;
  logic          lit;

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == 3'd5);

  always_comb begin
    cnt_next = cnt + CW'(1);
    idx_next = idx;
    if (tick) begin
      cnt_next = '0;
      idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= 3'd0;
      state <= S_BLANK;
    end else begin
      cnt   <= cnt_next;
      idx   <= idx_next;
      state <= state_next;
    end
  end

  // State tracks the counter value it is registered alongside, so look ahead at cnt_next.
  always_comb begin
    state_next = state;
    case (state)
      S_BLANK: if (int'(cnt_next) >= BLANK_CYC) state_next = S_DRIVE;
      S_DRIVE: if (tick && BLANK_CYC != 0) state_next = S_BLANK;
      default: state_next = S_BLANK;
    endcase
  end

  // The whole frame is captured at once on the last cycle of digit 5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_seg <= '0;
      shadow_dp  <= '0;
    end else if (frame_end) begin
      shadow_seg <= i_six_digit_seg;
      shadow_dp  <= i_six_dp;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;

  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg_scan_driver: BLINK_FRAMES must be >= 1");
  end

  logic [FW-1:0] frm_cnt;
  logic          blink_phase;
  logic [5:0]    shadow_mask;

  // Counting frame ends makes the toggle land exactly on the next frame's first digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      shadow_mask <= '0;
    end else if (frame_end) begin
      shadow_mask <= i_blink_mask;
      if (int'(frm_cnt) == BLINK_FRAMES - 1) begin
        frm_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frm_cnt <= frm_cnt + FW'(1);
      end
    end
  end

  assign blink_dark = blink_phase && (|(shadow_mask & enb_onehot));
`else
  assign blink_dark = 1'b0;
`endif

  always_comb begin
    enb_onehot = 6'd1 << idx;
    seg_sel    = '0;
    dp_sel     = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (idx == 3'(k)) begin
        seg_sel = shadow_seg[7*k +: 7];
        dp_sel  = shadow_dp[k];
      end
    end
    lit = (state == S_DRIVE) && !blink_dark;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg_enb     <= ENB_OFF;
      o_seg         <= SEG_OFF;
      o_seg_dp      <= DP_OFF;
      o_frame_start <= 1'b0;
    end else begin
      o_seg_enb     <= lit ? (enb_onehot ^ ENB_OFF) : ENB_OFF;
      o_seg         <= lit ? (seg_sel ^ SEG_OFF) : SEG_OFF;
      o_seg_dp      <= lit ? (dp_sel ^ DP_OFF) : DP_OFF;
      o_frame_start <= (cnt == '0) && (idx == 3'd0);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: two instances (BLANK_CYC=2 and 0) checked every cycle.
// Define SEG_BLINK_EN to also exercise digit blinking with BLINK_FRAMES=2.
`timescale 1ns/1ps
module tb_seg_scan_driver;
  localparam int D  = 8;
  localparam int B  = 2;
  localparam int FR = 6 * D;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [41:0] digits;
  logic [5:0]  dps;
  logic [5:0]  blink_mask;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fs_a, fs_b;
  logic [5:0]  enb_a, enb_b;

  int          errors = 0;
  int          checks = 0;
  logic [14:0] q_a[$];
  logic [14:0] q_b[$];
  int          t = 0;
  logic [41:0] m_seg = '0;
  logic [5:0]  m_dp = '0;
  logic [5:0]  m_mask = '0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIV_CNT(D), .BLANK_CYC(B), .ENB_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b0)
`ifdef SEG_BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_six_digit_seg(digits), .i_six_dp(dps),
`ifdef SEG_BLINK_EN
    .i_blink_mask(blink_mask),
`endif
    .o_seg(seg_a), .o_seg_dp(dp_a), .o_seg_enb(enb_a), .o_frame_start(fs_a)
  );

  seg_scan_driver #(.DIV_CNT(D), .BLANK_CYC(0), .ENB_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b0)
`ifdef SEG_BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_six_digit_seg(digits), .i_six_dp(dps),
`ifdef SEG_BLINK_EN
    .i_blink_mask(blink_mask),
`endif
    .o_seg(seg_b), .o_seg_dp(dp_b), .o_seg_enb(enb_b), .o_frame_start(fs_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected {enb, seg, dp, frame_start} for output cycle tt after reset release.
  function automatic logic [14:0] expect_out(input int tt, input int blank, input logic [41:0] sg,
                                             input logic [5:0] dp, input logic [5:0] mask);
    int c, k, f;
    logic lit;
    logic [5:0] e;
    logic [6:0] s;
    logic d;
    c = tt % D;
    k = (tt / D) % 6;
    f = tt / FR;
    lit = (c >= blank) && (tt != 0);
`ifdef SEG_BLINK_EN
    if (((f / BF) % 2 == 1) && mask[k]) lit = 1'b0;
`else
    if (f < 0 && mask != 6'd0) lit = 1'b0;
`endif
    e = 6'h3F;
    s = 7'h00;
    d = 1'b0;
    if (lit) begin
      e[k] = 1'b0;
      s = sg[7*k +: 7];
      d = dp[k];
    end
    return {e, s, d, (tt % FR == 0)};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0;
      m_seg = '0;
      m_dp = '0;
      m_mask = '0;
      q_a.delete();
      q_b.delete();
    end else begin
      q_a.push_back(expect_out(t, B, m_seg, m_dp, m_mask));
      q_b.push_back(expect_out(t, 0, m_seg, m_dp, m_mask));
      if (t % FR == FR - 1) begin
        m_seg = digits;
        m_dp = dps;
        m_mask = blink_mask;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    logic [14:0] exp_v;
    if (rst_n && q_a.size() > 0) begin
      exp_v = q_a.pop_front();
      chk("scan_blank2", {17'd0, enb_a, seg_a, dp_a, fs_a}, {17'd0, exp_v});
    end
    if (rst_n && q_b.size() > 0) begin
      exp_v = q_b.pop_front();
      chk("scan_blank0", {17'd0, enb_b, seg_b, dp_b, fs_b}, {17'd0, exp_v});
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_enb_a"}, {26'd0, enb_a}, 32'h3F);
    chk({tag, "_seg_a"}, {25'd0, seg_a}, 32'h0);
    chk({tag, "_dp_a"},  {31'd0, dp_a},  32'h0);
    chk({tag, "_fs_a"},  {31'd0, fs_a},  32'h0);
    chk({tag, "_enb_b"}, {26'd0, enb_b}, 32'h3F);
    chk({tag, "_seg_b"}, {25'd0, seg_b}, 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 6; k++) digits[7*k +: 7] = 7'(k + 1);
    dps = 6'b000100;
    blink_mask = 6'b000011;

    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst_n = 1'b1;

    // Mid frame 2, digit 2 on screen: swap in all-ones; must not show until frame 3.
    repeat (2 * FR + 20) @(negedge clk);
    chk("tear_pre_enb", {26'd0, enb_a}, 32'h3B);
    digits = '1;
    repeat (2 * FR) @(negedge clk);

    // Land in frame 4, digit 3 drive, then pull reset between edges.
    repeat (8) @(negedge clk);
    chk("pre_rst_enb", {26'd0, enb_a}, 32'h37);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst");
    repeat (2) @(negedge clk);
    chk_idle("held_rst");
    rst_n = 1'b1;

    repeat (FR) @(negedge clk);
    digits = {$urandom, $urandom};
    dps = 6'($urandom);
    repeat (9 * FR) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed scan driver for the six-digit 7-segment display. It consumes the 42-bit packed segment vector from the six-digit mode mux and a 6-bit decimal-point vector. It drives one digit at a time with anti-ghosting blanking between digits. Input data is captured once per frame so that a displayed frame never mixes old and new digits.

Parameters:
DIV_CNT, 50000, clk cycles per digit slot; must be >= 2
BLANK_CYC, 500, blank cycles at the start of each slot; must be < DIV_CNT (0 = no blanking)
ENB_ACT_LOW, 1, 1 = digit enables active-low (common anode)
SEG_ACT_LOW, 0, 1 = segment and dp outputs active-low

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_six_digit_seg  in  42  digit k segments in bits [7k+6:7k], k=0..5 (a..g, bit 0 = a)
i_six_dp  in  6  bit k = decimal point of digit k
o_seg  out  7  segment drive for the active digit
o_seg_dp  out  1  dp drive for the active digit
o_seg_enb  out  6  digit enables, bit k = digit k, at most one active
o_frame_start  out  1  one-cycle pulse marking the first output cycle of digit 0

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). During reset, all outputs are forced to their inactive levels.
  - o_seg_enb = all inactive (6'b111111 when ENB_ACT_LOW=1).
  - o_seg and o_seg_dp = inactive.
  - o_frame_start = 0.
  - Internal state: cnt=0, idx=0, state=S_BLANK, shadow seg/dp = 0.
- Slot counter: cnt runs 0..DIV_CNT-1.
  - tick = (cnt == DIV_CNT-1).
  - On tick: cnt -> 0 and idx -> (idx==5 ? 0 : idx+1).
- FSM (registered, derived from cnt):
  - S_BLANK while cnt < BLANK_CYC; S_DRIVE otherwise.
  - S_BLANK -> S_DRIVE when cnt reaches BLANK_CYC.
  - S_DRIVE -> S_BLANK on tick, or stays in S_DRIVE if BLANK_CYC=0.
- Shadow capture:
  - i_six_digit_seg and i_six_dp load into shadow registers on the tick where idx==5.
  - The new frame is therefore visible from digit 0 of the next frame.
  - Mid-frame input changes have no effect until the next frame.
- Outputs are registered: one cycle of latency from the internal (cnt, idx, state).
  - In S_DRIVE: enable bit idx active, all other enables inactive; o_seg = shadow[7*idx+6 -: 7]; o_seg_dp = shadow_dp[idx]. Polarity is applied per the parameters.
  - In S_BLANK: all enables, segments and dp inactive.
- o_frame_start = registered (cnt==0 && idx==0).
  - Pulses once per 6*DIV_CNT cycles.
  - Also pulses on the first clock edge after reset release; the shadow is 0, so that frame shows blank.
- Frame period = 6*DIV_CNT cycles. Each digit is active for DIV_CNT-BLANK_CYC cycles.
- Reset asserted mid-scan: outputs go inactive immediately (asynchronously). After release, scanning restarts at digit 0, cnt 0.
- Illegal parameters (BLANK_CYC >= DIV_CNT, or DIV_CNT < 2) trigger a generate-time $error.

Optional Feature:
Macro SEG_BLINK_EN.
- Defined:
  - Adds input i_blink_mask[5:0] and parameter BLINK_FRAMES (default 250).
  - A frame counter toggles blink_phase every BLINK_FRAMES frames, counted on o_frame_start. Reset: counter 0, blink_phase 0.
  - While blink_phase=1, any digit whose mask bit is set is treated as S_BLANK for its entire slot.
  - The mask is sampled with the shadow capture.
- Undefined: the port, parameter and logic are absent, and no digit is ever blanked by blinking.

Test Plan:
1. DIV_CNT=8, BLANK_CYC=2, digit k seg = k+1, dp=0.
   - Each 8-cycle slot shows 2 all-inactive cycles, then 6 cycles with enable k active and o_seg = k+1.
   - Order is 0..5; o_frame_start repeats every 48 cycles.
2. Tear-free capture: change all digits to 7'h7F while digit 2 is active.
   - Digits 3..5 keep their old values in that frame.
   - 7'h7F appears starting with the next o_frame_start.
3. Reset mid-scan: assert rst_n=0 during digit 3 drive.
   - Outputs go inactive in the same cycle, without waiting for an edge.
   - After release, the first active enable is digit 0, after BLANK_CYC cycles.
4. BLANK_CYC=0: no inactive cycles; the enable moves from digit k to k+1 on consecutive cycles.
5. i_six_dp=6'b000100: o_seg_dp is active only during the drive cycles of digit 2 and inactive at all other times.
6. SEG_BLINK_EN, BLINK_FRAMES=2, mask=6'b000011:
   - Digits 0 and 1 are dark in frames 2, 3, 6, 7 and lit in frames 0, 1, 4, 5.
   - Digits 2..5 are lit in every frame.
